// File: rtl/uart_tx_if.sv
// Byte request handshake between a byte-producing sender (master) and the UART transmitter (slave).
interface uart_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_accept;
   logic       tx_busy;

   modport master (output tx_valid, output tx_data, input tx_accept, input tx_busy);
   modport slave  (input tx_valid, input tx_data, output tx_accept, output tx_busy);
endinterface

// File: rtl/uart_tx_core.sv
// Byte-serial UART transmitter: 8 data bits LSB first, 1 or 2 stop bits, registered txd idling high.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1) after the data bits.
module uart_tx_core #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = 115200,
   parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_tx_if.slave tx,
   output logic     txd
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_core: CLK_FREQ/BAUD must be at least 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
      $error("uart_tx_core: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

   state_t        state_r;
   logic [CW-1:0] baud_cnt_r;
   logic [2:0]    bit_idx_r;
   logic          stop_idx_r;
   logic [7:0]    shift_r;
   logic          txd_r;
   logic          busy_r;
   logic          baud_last_s;

`ifdef UART_TX_PARITY_EN
   logic          parity_r;

   function automatic logic parity_of(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction
`endif

   assign baud_last_s  = (baud_cnt_r == BAUD_LAST);
   assign tx.tx_accept = tx.tx_valid & (state_r == ST_IDLE);
   assign tx.tx_busy   = busy_r;
   assign txd          = txd_r;

   // Frame sequencer: the byte and its parity are captured at accept so later tx_data changes are harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         txd_r      <= 1'b1;
         busy_r     <= 1'b0;
         baud_cnt_r <= '0;
         bit_idx_r  <= 3'd0;
         stop_idx_r <= 1'b0;
         shift_r    <= 8'h00;
`ifdef UART_TX_PARITY_EN
         parity_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               txd_r  <= 1'b1;
               busy_r <= 1'b0;
               if (tx.tx_valid) begin
                  shift_r    <= tx.tx_data;
                  baud_cnt_r <= '0;
                  stop_idx_r <= 1'b0;
                  state_r    <= ST_START;
                  busy_r     <= 1'b1;
                  txd_r      <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  parity_r   <= parity_of(tx.tx_data, PARITY_ODD);
`endif
               end
            end
            ST_START: begin
               if (baud_last_s) begin
                  baud_cnt_r <= '0;
                  txd_r      <= shift_r[0];
                  bit_idx_r  <= 3'd0;
                  state_r    <= ST_DATA;
               end else begin
                  baud_cnt_r <= baud_cnt_r + CW'(1);
               end
            end
            ST_DATA: begin
               if (baud_last_s) begin
                  baud_cnt_r <= '0;
                  if (bit_idx_r != 3'd7) begin
                     shift_r   <= {1'b0, shift_r[7:1]};
                     bit_idx_r <= bit_idx_r + 3'd1;
                     txd_r     <= shift_r[1];
                  end else begin
`ifdef UART_TX_PARITY_EN
                     txd_r   <= parity_r;
                     state_r <= ST_PARITY;
`else
                     txd_r   <= 1'b1;
                     state_r <= ST_STOP;
`endif
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + CW'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (baud_last_s) begin
                  baud_cnt_r <= '0;
                  txd_r      <= 1'b1;
                  state_r    <= ST_STOP;
               end else begin
                  baud_cnt_r <= baud_cnt_r + CW'(1);
               end
            end
`endif
            ST_STOP: begin
               if (baud_last_s) begin
                  baud_cnt_r <= '0;
                  if (stop_idx_r == STOP_LAST) begin
                     stop_idx_r <= 1'b0;
                     state_r    <= ST_IDLE;
                     busy_r     <= 1'b0;
                  end else begin
                     stop_idx_r <= 1'b1;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + CW'(1);
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               txd_r      <= 1'b1;
               busy_r     <= 1'b0;
               baud_cnt_r <= '0;
            end
         endcase
      end
   end

endmodule
